// File: rtl/led_chaser_ctrl_pkg.sv
// Shared encodings and helpers for the LED chaser sequencer.
package led_chaser_ctrl_pkg;

    localparam int MODE_W = 2;
    localparam int RATE_W = 5;

    typedef enum logic [MODE_W-1:0] {
        MODE_LEFT   = 2'd0,
        MODE_RIGHT  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // Faster rate is a smaller index; stepping past the fastest wraps to the slowest.
    function automatic logic [RATE_W-1:0] nextRate(
        input logic [RATE_W-1:0] cur,
        input logic [RATE_W-1:0] rateMin,
        input logic [RATE_W-1:0] rateMax
    );
        return (cur == rateMin) ? rateMax : (cur - RATE_W'(1));
    endfunction

endpackage

// File: rtl/led_chaser_ctrl_step_timer.sv
// Step divider: counts clocks up to 2^rateIdx-1 and flags the terminal count.
module led_chaser_ctrl_step_timer
    import led_chaser_ctrl_pkg::*;
#(
    parameter int DIV_W = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [RATE_W-1:0] rateIdx_i,
    input  logic              paused_i,
    input  logic              clear_i,
    input  logic              hold_i,
    output logic              tc_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] termCount;

    assign termCount = (DIV_W'(1) << rateIdx_i) - DIV_W'(1);
    assign tc_o      = !paused_i && (cnt_q == termCount);

    // Clear beats hold so a rate/mode press restarts the full period even while paused;
    // hold keeps the terminal value across a pause so unpausing steps immediately.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (hold_i) begin
            cnt_d = cnt_q;
        end else if (tc_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_chaser_ctrl.sv
// LED chaser sequencer: button edge detection, rate/mode/pause state and pattern stepping.
module led_chaser_ctrl
    import led_chaser_ctrl_pkg::*;
#(
    parameter int LED_W      = 18,
    parameter int DIV_W      = 26,
    parameter int RATE_MIN   = 16,
    parameter int RATE_MAX   = 25,
    parameter int RATE_RESET = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rate_btn,
    input  logic              mode_btn,
    input  logic              pause_btn,
    output logic [LED_W-1:0]  leds,
    output logic              step,
    output logic [RATE_W-1:0] rate_idx,
    output logic [MODE_W-1:0] mode,
    output logic              paused
);

    localparam logic [RATE_W-1:0] RATE_MIN_V   = RATE_W'(RATE_MIN);
    localparam logic [RATE_W-1:0] RATE_MAX_V   = RATE_W'(RATE_MAX);
    localparam logic [RATE_W-1:0] RATE_RESET_V = RATE_W'(RATE_RESET);

    logic              rateHist_q, modeHist_q, pauseHist_q;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic              step_q, step_d;
    logic [RATE_W-1:0] rateIdx_q, rateIdx_d;
    mode_e             mode_q, mode_d;
    logic              paused_q, paused_d;
    dir_e              dir_q, dir_d;

    logic              ratePress, modePress, pausePress, anyPress;
    logic              tc, stepFire, isOneHot;
    logic [LED_W-1:0]  patNext;
    dir_e              dirNext;

    assign ratePress  = rate_btn & ~rateHist_q;
    assign modePress  = mode_btn & ~modeHist_q;
    assign pausePress = pause_btn & ~pauseHist_q;
    assign anyPress   = ratePress | modePress | pausePress;
    assign stepFire   = tc & ~anyPress;
    assign isOneHot   = (leds_q != '0) && ((leds_q & (leds_q - LED_W'(1))) == '0);

    led_chaser_ctrl_step_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .rateIdx_i (rateIdx_q),
        .paused_i  (paused_q),
        .clear_i   (ratePress | modePress),
        .hold_i    (paused_q | pausePress),
        .tc_o      (tc)
    );

    // Pattern the LEDs would take on the next step in the current mode.
    always_comb begin
        patNext = leds_q;
        dirNext = dir_q;
        case (mode_q)
            MODE_LEFT: begin
                patNext = isOneHot ? {leds_q[LED_W-2:0], leds_q[LED_W-1]} : LED_W'(1);
            end
            MODE_RIGHT: begin
                patNext = isOneHot ? {leds_q[0], leds_q[LED_W-1:1]} : LED_W'(1);
            end
            MODE_BOUNCE: begin
                if (!isOneHot) begin
                    patNext = LED_W'(1);
                    dirNext = DIR_UP;
                end else if (dir_q == DIR_UP) begin
                    if (leds_q[LED_W-1]) begin
                        patNext = leds_q >> 1;
                        dirNext = DIR_DN;
                    end else begin
                        patNext = leds_q << 1;
                        if (leds_q[LED_W-2]) dirNext = DIR_DN;
                    end
                end else begin
                    if (leds_q[0]) begin
                        patNext = leds_q << 1;
                        dirNext = DIR_UP;
                    end else begin
                        patNext = leds_q >> 1;
                        if (leds_q[1]) dirNext = DIR_UP;
                    end
                end
            end
            MODE_FILL: begin
                patNext = (&leds_q) ? LED_W'(1) : {leds_q[LED_W-2:0], 1'b1};
            end
            default: begin
                patNext = LED_W'(1);
            end
        endcase
    end

    // Presses take priority over a coincident terminal count, so the step is simply dropped.
    always_comb begin
        leds_d    = leds_q;
        step_d    = 1'b0;
        rateIdx_d = rateIdx_q;
        mode_d    = mode_q;
        paused_d  = paused_q;
        dir_d     = dir_q;
        if (ratePress) begin
            rateIdx_d = nextRate(rateIdx_q, RATE_MIN_V, RATE_MAX_V);
        end
        if (modePress) begin
            mode_d = mode_e'(mode_q + 2'd1);
            leds_d = LED_W'(1);
            dir_d  = DIR_UP;
        end
        if (pausePress) begin
            paused_d = ~paused_q;
        end
        if (stepFire) begin
            leds_d = patNext;
            dir_d  = dirNext;
            step_d = 1'b1;
        end
    end

    // State and button history; history resets high so a button held through reset is ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rateHist_q  <= 1'b1;
            modeHist_q  <= 1'b1;
            pauseHist_q <= 1'b1;
            leds_q      <= LED_W'(1);
            step_q      <= 1'b0;
            rateIdx_q   <= RATE_RESET_V;
            mode_q      <= MODE_LEFT;
            paused_q    <= 1'b0;
            dir_q       <= DIR_UP;
        end else begin
            rateHist_q  <= rate_btn;
            modeHist_q  <= mode_btn;
            pauseHist_q <= pause_btn;
            leds_q      <= leds_d;
            step_q      <= step_d;
            rateIdx_q   <= rateIdx_d;
            mode_q      <= mode_d;
            paused_q    <= paused_d;
            dir_q       <= dir_d;
        end
    end

    assign leds     = leds_q;
    assign step     = step_q;
    assign rate_idx = rateIdx_q;
    assign mode     = mode_q;
    assign paused   = paused_q;

endmodule
